// File: rtl/dual_mult_pkg.sv
// Shared widths, scheduler state encoding and the buffered result record
// for dual_mult_sched and its result FIFO.
package dual_mult_pkg;

    localparam int A_W   = 8;
    localparam int C_W   = 8;
    localparam int P_W   = 16;
    localparam int TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic signed [P_W-1:0] ac;
        logic signed [P_W-1:0] bc;
        logic [TAG_W-1:0]      tag;
    } result_t;

endpackage

// File: rtl/dsp_dual_mult.sv
// Dual multiplier sharing operand c: ac = a*c, bc = b*c, LAT register stages.
// a/b are signed, c is unsigned; products are truncated to P_W bits.
module dsp_dual_mult #(
    parameter int A_W = 8,
    parameter int C_W = 8,
    parameter int P_W = 16,
    parameter int LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic signed [A_W-1:0] a,
    input  logic signed [A_W-1:0] b,
    input  logic [C_W-1:0]        c,
    output logic                  valid_out,
    output logic signed [P_W-1:0] ac,
    output logic signed [P_W-1:0] bc
);

    function automatic logic signed [P_W-1:0] mul_trunc(
        input logic signed [A_W-1:0] x,
        input logic [C_W-1:0]        y
    );
        logic signed [P_W-1:0] xe;
        logic signed [P_W-1:0] ye;
        xe = P_W'(x);
        ye = $signed(P_W'(y));
        return xe * ye;
    endfunction

    logic signed [P_W-1:0] ac_p [LAT];
    logic signed [P_W-1:0] bc_p [LAT];
    logic [LAT-1:0]        vld_p;

    // Data stages advance every cycle; only the valid bits are reset.
    always_ff @(posedge clk) begin
        ac_p[0] <= mul_trunc(a, c);
        bc_p[0] <= mul_trunc(b, c);
        for (int i = 1; i < LAT; i++) begin
            ac_p[i] <= ac_p[i-1];
            bc_p[i] <= bc_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= en;
            for (int i = 1; i < LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign valid_out = vld_p[LAT-1];
    assign ac        = ac_p[LAT-1];
    assign bc        = bc_p[LAT-1];

endmodule

// File: rtl/sync_fifo_res.sv
// Result FIFO of result_t, DEPTH entries (power of 2), with occupancy output.
// A write while full is accepted when a pop happens in the same cycle.
module sync_fifo_res
    import dual_mult_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  result_t                wr_data,
    input  logic                   rd_en,
    output result_t                rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    result_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_wr, do_rd;

    always_comb begin
        do_rd    = rd_en && (count_q != '0);
        do_wr    = wr_en && ((count_q != CW'(DEPTH)) || do_rd);
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/dual_mult_sched.sv
// Credit-based scheduler feeding one dsp_dual_mult and buffering results in sync_fifo_res.
// Define DUAL_MULT_CHECK_EN to add a shadow-model result check and the sticky chk_err port.
module dual_mult_sched
    import dual_mult_pkg::*;
#(
    parameter int MULT_LAT = 3,
    parameter int FIFO_D   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [A_W-1:0] in_a,
    input  logic signed [A_W-1:0] in_b,
    input  logic [C_W-1:0]        in_c,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [P_W-1:0] out_ac,
    output logic signed [P_W-1:0] out_bc,
    output logic [TAG_W-1:0]      out_tag,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  busy
`ifdef DUAL_MULT_CHECK_EN
    ,
    output logic                  chk_err
`endif
);

    localparam int CNT_W = $clog2(FIFO_D) + 1;

    sched_state_e          state_q, state_d;
    logic                  flush_done_q, flush_done_d;
    logic [MULT_LAT-1:0]   vld_q, vld_d;
    logic [TAG_W-1:0]      tag_q [MULT_LAT];
    logic                  issue, pop, fifo_empty, dsp_vld, res_wr;
    logic [CNT_W-1:0]      fifo_cnt, used;
    logic signed [P_W-1:0] dsp_ac, dsp_bc;
    result_t               wr_res, rd_res;

    // Credits in use: jobs still in the multiplier plus results waiting in the FIFO.
    always_comb begin
        used = fifo_cnt;
        for (int i = 0; i < MULT_LAT; i++) begin
            used = used + CNT_W'(vld_q[i]);
        end
    end

    assign pop      = out_valid && out_ready;
    assign in_ready = (state_q == RUN) && !flush && ((used < CNT_W'(FIFO_D)) || pop);
    assign issue    = in_valid && in_ready;
    assign res_wr   = vld_q[MULT_LAT-1];

    always_comb begin
        vld_d[0] = issue;
        for (int i = 1; i < MULT_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   if (used == '0) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = IDLE;
        endcase
        flush_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            flush_done_q <= 1'b0;
            vld_q        <= '0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
            vld_q        <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q[0] <= in_tag;
        for (int i = 1; i < MULT_LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    dsp_dual_mult #(
        .A_W (A_W),
        .C_W (C_W),
        .P_W (P_W),
        .LAT (MULT_LAT)
    ) u_dsp (
        .clk       (clk),
        .rst       (~rst),
        .en        (issue),
        .a         (in_a),
        .b         (in_b),
        .c         (in_c),
        .valid_out (dsp_vld),
        .ac        (dsp_ac),
        .bc        (dsp_bc)
    );

    assign wr_res = '{ac: dsp_ac, bc: dsp_bc, tag: tag_q[MULT_LAT-1]};

    sync_fifo_res #(
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (res_wr),
        .wr_data (wr_res),
        .rd_en   (pop),
        .rd_data (rd_res),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    // FIFO storage is never reset, so the data outputs are forced to zero while empty.
    assign out_valid  = !fifo_empty;
    assign out_ac     = out_valid ? rd_res.ac  : '0;
    assign out_bc     = out_valid ? rd_res.bc  : '0;
    assign out_tag    = out_valid ? rd_res.tag : '0;
    assign flush_done = flush_done_q;
    assign busy       = (state_q != IDLE) || (used != '0) || dsp_vld;

`ifdef DUAL_MULT_CHECK_EN
    logic signed [P_W-1:0] exp_ac_q [MULT_LAT];
    logic signed [P_W-1:0] exp_bc_q [MULT_LAT];
    logic signed [P_W-1:0] shadow_c;
    logic                  chk_err_q;
    logic                  chk_bad;

    assign shadow_c = $signed(P_W'({1'b0, in_c}));

    always_ff @(posedge clk) begin
        exp_ac_q[0] <= P_W'(in_a) * shadow_c;
        exp_bc_q[0] <= P_W'(in_b) * shadow_c;
        for (int i = 1; i < MULT_LAT; i++) begin
            exp_ac_q[i] <= exp_ac_q[i-1];
            exp_bc_q[i] <= exp_bc_q[i-1];
        end
    end

    assign chk_bad = res_wr && (!dsp_vld || (exp_ac_q[MULT_LAT-1] != dsp_ac) ||
                                (exp_bc_q[MULT_LAT-1] != dsp_bc));

    always_ff @(posedge clk) begin
        if (!rst) begin
            chk_err_q <= 1'b0;
        end else if (chk_bad) begin
            chk_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && res_wr) begin
            assert (!chk_bad)
            else $error("dual_mult_sched: DSP result disagrees with shadow model");
        end
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_dual_mult_sched.sv
// Directed and randomised bench for dual_mult_sched (MULT_LAT=3, FIFO_D=8).
// Build with DUAL_MULT_CHECK_EN to also watch chk_err.
module tb_dual_mult_sched;

    localparam int MULT_LAT = 3;
    localparam int FIFO_D   = 8;

    typedef struct packed {
        logic signed [15:0] ac;
        logic signed [15:0] bc;
        logic [3:0]         tag;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic               flush = 1'b0;
    logic signed [7:0]  in_a = '0;
    logic signed [7:0]  in_b = '0;
    logic [7:0]         in_c = '0;
    logic [3:0]         in_tag = '0;
    logic               in_ready, out_valid, flush_done, busy;
    logic signed [15:0] out_ac, out_bc;
    logic [3:0]         out_tag;
`ifdef DUAL_MULT_CHECK_EN
    logic               chk_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dual_mult_sched #(
        .MULT_LAT (MULT_LAT),
        .FIFO_D   (FIFO_D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ac     (out_ac),
        .out_bc     (out_bc),
        .out_tag    (out_tag),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy)
`ifdef DUAL_MULT_CHECK_EN
        ,
        .chk_err    (chk_err)
`endif
    );

    function automatic logic signed [15:0] ref_mul(input int x, input int y);
        int p;
        p = x * y;
        return p[15:0];
    endfunction

    task automatic send_job(input logic signed [7:0] a, input logic signed [7:0] b,
                            input logic [7:0] c, input logic [3:0] tag, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_tag = tag;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output bit ok, output logic signed [15:0] ac,
                               output logic signed [15:0] bc, output logic [3:0] tag);
        ok = 1'b0; ac = '0; bc = '0; tag = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1; ac = out_ac; bc = out_bc; tag = out_tag;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL rst_flush_done got=%b want=0", flush_done); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (out_ac !== 16'sd0)   begin bad++; $display("FAIL rst_out_ac got=%0d want=0", out_ac); end
        total++; if (out_bc !== 16'sd0)   begin bad++; $display("FAIL rst_out_bc got=%0d want=0", out_bc); end
        total++; if (out_tag !== 4'd0)    begin bad++; $display("FAIL rst_out_tag got=%0d want=0", out_tag); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL run_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        bit acc;
        int n;
        acc = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'(-3); in_b = 8'sd5; in_c = 8'd200; in_tag = 4'd2;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL single_accept got=%b want=1", acc); end
        for (n = 1; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
        end
        total++; if (n != MULT_LAT + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", n, MULT_LAT + 1); end
        total++; if (out_ac !== -16'sd600) begin bad++; $display("FAIL single_ac got=%0d want=-600", out_ac); end
        total++; if (out_bc !== 16'sd1000) begin bad++; $display("FAIL single_bc got=%0d want=1000", out_bc); end
        total++; if (out_tag !== 4'd2)     begin bad++; $display("FAIL single_tag got=%0d want=2", out_tag); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=%b want=0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_corners();
        bit ok1, ok2, r1, r2;
        logic signed [15:0] ac, bc;
        logic [3:0] tag;
        out_ready = 1'b1;
        send_job(8'(-128), 8'sd127, 8'd255, 4'd5, ok1);
        send_job(8'sd0, 8'(-1), 8'd0, 4'd6, ok2);
        total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL corner_accept got=%b%b want=11", ok1, ok2); end
        wait_result(r1, ac, bc, tag);
        total++; if (!r1 || ac !== -16'sd32640 || bc !== 16'sd32385 || tag !== 4'd5) begin
            bad++; $display("FAIL corner_max got=%b %0d %0d %0d want=1 -32640 32385 5", r1, ac, bc, tag);
        end
        wait_result(r2, ac, bc, tag);
        total++; if (!r2 || ac !== 16'sd0 || bc !== 16'sd0 || tag !== 4'd6) begin
            bad++; $display("FAIL corner_zero got=%b %0d %0d %0d want=1 0 0 6", r2, ac, bc, tag);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int recv = 0;
        int stall_acc;
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            in_valid = (acc < 10);
            in_a = 8'(acc + 1); in_b = 8'(-(acc + 1)); in_c = 8'd100; in_tag = 4'(acc);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        stall_acc = acc;
        total++; if (stall_acc != FIFO_D) begin bad++; $display("FAIL bp_stall_accepts got=%0d want=%0d", stall_acc, FIFO_D); end
        out_ready = 1'b1;
        for (int k = 0; k < 100 && recv < 10; k++) begin
            in_valid = (acc < 10);
            in_a = 8'(acc + 1); in_b = 8'(-(acc + 1)); in_c = 8'd100; in_tag = 4'(acc);
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (out_ac !== 16'((recv + 1) * 100) || out_bc !== 16'(-(recv + 1) * 100) || out_tag !== 4'(recv)) begin
                    bad++; $display("FAIL bp_result idx=%0d got=%0d %0d %0d want=%0d %0d %0d",
                                    recv, out_ac, out_bc, out_tag, (recv + 1) * 100, -(recv + 1) * 100, recv);
                end
                recv++;
            end
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++; if (recv != 10 || acc != 10) begin bad++; $display("FAIL bp_count got=%0d/%0d want=10/10", recv, acc); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t cur, e;
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        int vd, rd;
        bit accepted;
        out_ready = 1'b0; in_valid = 1'b0; cur = '0;
        while ((sent < 1000 || recv < 1000) && cyc < 40000) begin
            case (sent / 250)
                0: vd = 90; 1: vd = 30; 2: vd = 70; default: vd = 50;
            endcase
            case (recv / 250)
                0: rd = 80; 1: rd = 25; 2: rd = 100; default: rd = 50;
            endcase
            if (!in_valid && sent < 1000 && $urandom_range(0, 99) < vd) begin
                in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom); in_tag = 4'($urandom);
                cur.ac = ref_mul(int'(in_a), int'(in_c));
                cur.bc = ref_mul(int'(in_b), int'(in_c));
                cur.tag = in_tag;
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 99) < rd);
            accepted = 1'b0;
            @(negedge clk);
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rnd_unexpected got=%0d %0d %0d want=none", out_ac, out_bc, out_tag);
                end else begin
                    e = q.pop_front();
                    if (out_ac !== e.ac || out_bc !== e.bc || out_tag !== e.tag) begin
                        bad++;
                        if (bad < 20) $display("FAIL rnd_result idx=%0d got=%0d %0d %0d want=%0d %0d %0d",
                                               recv, out_ac, out_bc, out_tag, e.ac, e.bc, e.tag);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(cur);
                sent++;
                accepted = 1'b1;
            end
            @(posedge clk); #1;
            if (accepted) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (recv != 1000 || sent != 1000 || q.size() != 0) begin
            bad++; $display("FAIL rnd_count got=%0d/%0d left=%0d want=1000/1000 left=0", sent, recv, q.size());
        end
`ifdef DUAL_MULT_CHECK_EN
        total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL rnd_chk_err got=%b want=0", chk_err); end
`endif
    endtask

    task automatic test_flush();
        bit ok;
        int sends = 0;
        int recv = 0;
        int done_cnt = 0;
        int early_done = 0;
        int rdy_bad = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_job(8'(i + 1), 8'(2 * (i + 1)), 8'd10, 4'(8 + i), ok);
            if (ok) sends++;
        end
        total++; if (sends != 5) begin bad++; $display("FAIL flush_setup got=%0d want=5", sends); end
        flush = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'sd50; in_b = 8'sd50; in_c = 8'd1; in_tag = 4'd15;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_cycle_ready got=%b want=0", in_ready); end
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_buffered got=%b want=1", out_valid); end
            end
            if (out_valid) begin
                total++;
                if (out_ac !== 16'((recv + 1) * 10) || out_bc !== 16'(2 * (recv + 1) * 10) || out_tag !== 4'(8 + recv)) begin
                    bad++; $display("FAIL flush_result idx=%0d got=%0d %0d %0d want=%0d %0d %0d",
                                    recv, out_ac, out_bc, out_tag, (recv + 1) * 10, 2 * (recv + 1) * 10, 8 + recv);
                end
                recv++;
            end
            if (in_ready && done_cnt == 0) rdy_bad++;
            if (flush_done) begin
                done_cnt++;
                if (recv != 5) early_done++;
            end
            @(posedge clk); #1;
            flush = 1'b0; in_valid = 1'b0;
        end
        total++; if (recv != 5)       begin bad++; $display("FAIL flush_delivered got=%0d want=5", recv); end
        total++; if (done_cnt != 1)   begin bad++; $display("FAIL flush_done_pulses got=%0d want=1", done_cnt); end
        total++; if (early_done != 0) begin bad++; $display("FAIL flush_done_early got=%0d want=0", early_done); end
        total++; if (rdy_bad != 0)    begin bad++; $display("FAIL flush_drain_ready got=%0d want=0", rdy_bad); end
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_back_to_run got=%b want=1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit ok, r;
        int sends = 0;
        int stale = 0;
        logic signed [15:0] ac, bc;
        logic [3:0] tag;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_job(8'(i + 1), 8'(i + 2), 8'd3, 4'(i), ok);
            if (ok) sends++;
        end
        total++; if (sends != 6 || out_valid !== 1'b1) begin
            bad++; $display("FAIL rstmid_fill got=%0d %b want=6 1", sends, out_valid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || flush_done !== 1'b0) begin
            bad++; $display("FAIL rstmid_ctrl got=%b%b%b%b want=0000", in_ready, out_valid, busy, flush_done);
        end
        total++; if (out_ac !== 16'sd0 || out_bc !== 16'sd0 || out_tag !== 4'd0) begin
            bad++; $display("FAIL rstmid_data got=%0d %0d %0d want=0 0 0", out_ac, out_bc, out_tag);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (out_valid) stale++;
        end
        @(posedge clk); #1;
        total++; if (stale != 0) begin bad++; $display("FAIL rstmid_stale got=%0d want=0", stale); end
        send_job(8'sd7, 8'(-7), 8'd9, 4'd3, ok);
        wait_result(r, ac, bc, tag);
        total++; if (!ok || !r || ac !== 16'sd63 || bc !== -16'sd63 || tag !== 4'd3) begin
            bad++; $display("FAIL rstmid_recover got=%b%b %0d %0d %0d want=11 63 -63 3", ok, r, ac, bc, tag);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_corners();
        test_backpressure();
        test_random();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
